gesture_servo_ramp: RTL and testbench
=====================================

// Module: gesture_servo_ramp
// PURPOSE
//  Parametrised gesture-to-servo pose engine for the bionic hand. A gesture code is mapped
//  to a run-time programmable NUM_CH-channel pose table. Each channel's pulse width then
//  slews toward its target at a bounded rate, once per servo frame.
//  Width outputs drive external servo_pwm instances (one per channel).
// PARAMETERS
//  NUM_CH      5          servo channel count (>=1)
//  GEST_W      8          gesture code width
//  NUM_GEST    16         pose table entries; legal codes 1..NUM_GEST-1
//  WIDTH_W     16         pulse-width field width, microseconds
//  TICK_DIV    1_000_000  clk cycles per slew update (50 MHz / 50 Hz frame)
//  STEP_US     20         max width change per channel per tick
//  MIN_US      1000       lower clamp; MAX_US 2000 upper clamp; DEFAULT_US 1500 reset pose
// PORTS
//  clk            in   1                 system clock
//  reset          in   1                 async reset, active low
//  gesture_valid  in   1                 1-cycle strobe: gesture is a request
//  gesture        in   GEST_W            requested gesture code
//  tbl_we         in   1                 pose table write enable
//  tbl_addr       in   GEST_W            table entry (gesture code) to write
//  tbl_ch         in   $clog2(NUM_CH)    channel within entry
//  tbl_data       in   WIDTH_W           width to store, us
//  width_us       out  NUM_CH*WIDTH_W    current widths, ch0 in LSBs
//  active_gesture out  GEST_W            last accepted gesture code
//  busy           out  1                 high in LOAD and RAMP
//  done           out  1                 1-cycle pulse when every channel reaches target
//  err            out  1                 1-cycle pulse on illegal gesture or table write
// BEHAVIOUR
//  Reset (async, any state): every table entry and width = DEFAULT_US, targets = DEFAULT_US,
//   tick counter 0, state IDLE, active_gesture/busy/done/err = 0.
//  Table: tbl_we with tbl_addr<NUM_GEST and tbl_ch<NUM_CH writes the entry at the clock edge,
//   data clamped to [MIN_US,MAX_US]; out-of-range addr/ch -> no write, err pulses next cycle.
//  Gesture accept: gesture_valid with 1<=gesture<NUM_GEST is accepted in ANY state;
//   active_gesture updates, state -> LOAD. Code 0 = hold, ignored silently. Code >=NUM_GEST
//   ignored, err pulse next cycle.
//  LOAD (1 cycle): targets <= table[active_gesture], including a write made in the
//   acceptance cycle. -> RAMP. Later writes never alter latched targets.
//  Tick: free-running counter 0..TICK_DIV-1, never reset by gestures. Tick = 1 cycle at wrap.
//  RAMP: per tick, per channel: diff = target-cur; cur += sign(diff)*min(STEP_US,|diff|).
//   No overshoot; channels independent. Cycle after all cur==target: done=1, -> IDLE.
//   Target equal to current pose: done pulses on first RAMP cycle, no tick needed.
//  Retarget: gesture accepted during LOAD/RAMP -> LOAD again; ramp continues from present
//   widths, no done pulse for the abandoned gesture.
//  Simultaneous accept and done cycle: accept wins, done suppressed.
//  width_us outputs are registered; never leave [MIN_US,MAX_US].
// TESTING (bench overrides TICK_DIV=10)
//  1 Release reset -> all width_us=1500, busy=0, done=0, active_gesture=0.
//  2 Write entry 1 all ch=2000, strobe gesture=1 -> busy next cycle; widths 1520,1540..;
//    2000 after 25 ticks; done pulse once, busy low.
//  3 Entry 2 ch0=1510 others=1500, gesture=2 -> ch0 hits 1510 on first tick (no overshoot),
//    done the following cycle.
//  4 Write 2500 and 500 to entry 3 ch0/ch1 -> gesture 3 ramps to 2000/1000;
//    tbl_addr=20 write -> err pulse, table unchanged.
//  5 gesture=0 -> no change; gesture=16 -> err pulse, state and widths unchanged.
//  6 Mid-ramp (width 1700) accept gesture to all-1000 pose -> reverses from 1700, no done
//    for first gesture; assert reset mid-ramp -> widths 1500, busy 0 immediately.

Source files
------------

// File: rtl/gesture_servo_ramp.sv
// gesture_servo_ramp: gesture-selected pose table with per-channel rate-limited servo width slewing
module gesture_servo_ramp #(
  parameter int NUM_CH     = 5,
  parameter int GEST_W     = 8,
  parameter int NUM_GEST   = 16,
  parameter int WIDTH_W    = 16,
  parameter int TICK_DIV   = 1_000_000,
  parameter int STEP_US    = 20,
  parameter int MIN_US     = 1000,
  parameter int MAX_US     = 2000,
  parameter int DEFAULT_US = 1500
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        gesture_valid,
  input  logic [GEST_W-1:0]           gesture,
  input  logic                        tbl_we,
  input  logic [GEST_W-1:0]           tbl_addr,
  input  logic [$clog2(NUM_CH)-1:0]   tbl_ch,
  input  logic [WIDTH_W-1:0]          tbl_data,
  output logic [NUM_CH*WIDTH_W-1:0]   width_us,
  output logic [GEST_W-1:0]           active_gesture,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  localparam int AW = NUM_GEST > 1 ? $clog2(NUM_GEST) : 1;
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [WIDTH_W-1:0] W_MIN  = WIDTH_W'(MIN_US);
  localparam logic [WIDTH_W-1:0] W_MAX  = WIDTH_W'(MAX_US);
  localparam logic [WIDTH_W-1:0] W_DEF  = WIDTH_W'(DEFAULT_US);
  localparam logic [WIDTH_W-1:0] W_STEP = WIDTH_W'(STEP_US);
  typedef enum logic [1:0] {IDLE, LOAD, RAMP} state_t;
  state_t state, state_nx;
  logic [WIDTH_W-1:0] tbl [NUM_GEST][NUM_CH];
  logic [WIDTH_W-1:0] cur [NUM_CH];
  logic [WIDTH_W-1:0] tgt [NUM_CH];
  logic [WIDTH_W-1:0] nxt [NUM_CH];
  logic [CW-1:0] cnt;
  logic [WIDTH_W-1:0] wdata;
  logic tick, acc, bad_g, wr_ok, all_eq;
  assign tick  = cnt == CW'(TICK_DIV - 1);
  assign acc   = gesture_valid && gesture != '0 && 32'(gesture) < NUM_GEST;
  assign bad_g = gesture_valid && 32'(gesture) >= NUM_GEST;
  assign wr_ok = tbl_we && 32'(tbl_addr) < NUM_GEST && 32'(tbl_ch) < NUM_CH;
  assign wdata = tbl_data < W_MIN ? W_MIN : tbl_data > W_MAX ? W_MAX : tbl_data;
  assign busy  = state != IDLE;
  assign done  = state == RAMP && all_eq && !acc;
  // a fresh accept always wins over finishing the current ramp
  assign state_nx = acc ? LOAD : state == LOAD ? RAMP : (state == RAMP && all_eq) ? IDLE : state;
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      all_eq = all_eq && cur[i] == tgt[i];
      nxt[i] = tgt[i] > cur[i] ? (tgt[i] - cur[i] > W_STEP ? cur[i] + W_STEP : tgt[i])
                               : (cur[i] - tgt[i] > W_STEP ? cur[i] - W_STEP : tgt[i]);
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign width_us[c*WIDTH_W +: WIDTH_W] = cur[c];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      active_gesture <= '0;
      err            <= 1'b0;
      for (int i = 0; i < NUM_GEST; i++)
        for (int j = 0; j < NUM_CH; j++)
          tbl[i][j] <= W_DEF;
      for (int j = 0; j < NUM_CH; j++) begin
        cur[j] <= W_DEF;
        tgt[j] <= W_DEF;
      end
    end else begin
      state <= state_nx;
      cnt   <= tick ? '0 : cnt + 1'b1;
      err   <= bad_g || (tbl_we && !wr_ok);
      if (acc) active_gesture <= gesture;
      if (wr_ok) tbl[tbl_addr[AW-1:0]][tbl_ch] <= wdata;
      for (int j = 0; j < NUM_CH; j++) begin
        if (state == LOAD) tgt[j] <= tbl[active_gesture[AW-1:0]][j];
        if (state == RAMP && tick) cur[j] <= nxt[j];
      end
    end
  end
endmodule

// File: tb/tb_gesture_servo_ramp.sv
// tb_gesture_servo_ramp: randomized and directed checks against a cycle-level pose model
module tb_gesture_servo_ramp;
  localparam int NC = 5, GW = 8, NG = 16, WW = 16, TD = 10;
  logic clk = 0, reset = 0, gesture_valid = 0, tbl_we = 0;
  logic [GW-1:0] gesture = 0, tbl_addr = 0;
  logic [2:0] tbl_ch = 0;
  logic [WW-1:0] tbl_data = 0;
  logic [NC*WW-1:0] width_us;
  logic [GW-1:0] active_gesture;
  logic busy, done, err;
  int errors = 0, checks = 0;
  int m_tbl [NG][NC];
  int m_cur [NC];
  int m_tgt [NC];
  int m_cnt, m_act;
  bit m_load, m_ramp, m_err;
  int cyc_n = 0, e_done_n = 0, o_done_n = 0, e_done_at = -1, o_done_at = -1;

  gesture_servo_ramp #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .gesture_valid(gesture_valid), .gesture(gesture),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_ch(tbl_ch), .tbl_data(tbl_data),
    .width_us(width_us), .active_gesture(active_gesture), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [NC*WW-1:0] exp_w();
    logic [NC*WW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*WW +: WW] = WW'(m_cur[c]);
    return v;
  endfunction

  task automatic m_reset();
    for (int g = 0; g < NG; g++) for (int c = 0; c < NC; c++) m_tbl[g][c] = 1500;
    for (int c = 0; c < NC; c++) begin m_cur[c] = 1500; m_tgt[c] = 1500; end
    m_cnt = 0; m_act = 0; m_load = 0; m_ramp = 0; m_err = 0;
  endtask

  // one clock cycle: inputs already driven at the preceding negedge
  task automatic cyc();
    bit acc, eq, dn, tick, wok;
    int d, v;
    #1;
    acc = gesture_valid && gesture != 0 && gesture < NG;
    eq = 1;
    for (int c = 0; c < NC; c++) if (m_cur[c] != m_tgt[c]) eq = 0;
    dn = m_ramp && eq && !acc;
    tick = m_cnt == TD - 1;
    if (done === 1'b1) begin o_done_n++; o_done_at = cyc_n; end
    if (dn) begin e_done_n++; e_done_at = cyc_n; end
    @(posedge clk);
    if (m_load) begin
      for (int c = 0; c < NC; c++) m_tgt[c] = m_tbl[m_act][c];
      m_load = 0; m_ramp = 1;
    end else if (m_ramp) begin
      if (dn) m_ramp = 0;
      else if (tick)
        for (int c = 0; c < NC; c++) begin
          d = m_tgt[c] - m_cur[c];
          m_cur[c] += d > 20 ? 20 : (d < -20 ? -20 : d);
        end
    end
    if (acc) begin m_act = gesture; m_load = 1; m_ramp = 0; end
    wok = tbl_we && tbl_addr < NG && tbl_ch < NC;
    if (wok) begin
      v = tbl_data < 1000 ? 1000 : (tbl_data > 2000 ? 2000 : int'(tbl_data));
      m_tbl[tbl_addr][tbl_ch] = v;
    end
    m_err = (tbl_we && !wok) || (gesture_valid && gesture >= NG);
    m_cnt = (m_cnt + 1) % TD;
    cyc_n++;
    @(negedge clk);
    gesture_valid = 0; tbl_we = 0;
  endtask

  task automatic wr(input int a, input int c, input int d);
    tbl_we = 1; tbl_addr = GW'(a); tbl_ch = 3'(c); tbl_data = WW'(d);
    cyc();
  endtask

  task automatic gest(input int g);
    gesture_valid = 1; gesture = GW'(g);
    cyc();
  endtask

  task automatic settle(output bit to);
    to = 1;
    for (int k = 0; k < 600; k++) begin
      if (!(m_load || m_ramp)) begin to = 0; break; end
      cyc();
    end
  endtask

  task automatic do_reset();
    reset = 0; gesture_valid = 0; tbl_we = 0;
    #17;
    @(negedge clk);
    reset = 1;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (width_us !== {NC{16'd1500}}) begin errors++; $display("FAIL reset_width: got %h want %h", width_us, {NC{16'd1500}}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (active_gesture !== 8'd0) begin errors++; $display("FAIL reset_active: got %0d want 0", active_gesture); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_full_ramp();
    int d0;
    bit to;
    for (int c = 0; c < NC; c++) wr(1, c, 2000);
    d0 = o_done_n;
    gest(1);
    checks++; if (busy !== 1'b1 || active_gesture !== 8'd1) begin errors++; $display("FAIL accept: got busy=%b act=%0d want busy=1 act=1", busy, active_gesture); end
    to = 1;
    for (int k = 0; k < 400; k++) begin
      cyc();
      checks++; if (width_us !== exp_w()) begin errors++; $display("FAIL ramp_width: got %h want %h", width_us, exp_w()); end
      if (!(m_load || m_ramp)) begin to = 0; break; end
    end
    checks++; if (to) begin errors++; $display("FAIL ramp_timeout: got busy=%b want finished", busy); end
    checks++; if (width_us !== {NC{16'd2000}}) begin errors++; $display("FAIL ramp_final: got %h want %h", width_us, {NC{16'd2000}}); end
    checks++; if (o_done_n - d0 != 1 || o_done_at != e_done_at) begin errors++; $display("FAIL ramp_done: got n=%0d at=%0d want n=1 at=%0d", o_done_n - d0, o_done_at, e_done_at); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy: got %b want 0", busy); end
  endtask

  task automatic test_small_step();
    int hit = -1;
    bit to;
    do_reset();
    wr(2, 0, 1510);
    gest(2);
    to = 1;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (hit < 0 && width_us[15:0] == 16'd1510) hit = cyc_n;
      if (!(m_load || m_ramp)) begin to = 0; break; end
    end
    checks++; if (to) begin errors++; $display("FAIL small_timeout: got busy=%b want finished", busy); end
    checks++; if (width_us !== {{(NC-1){16'd1500}}, 16'd1510}) begin errors++; $display("FAIL small_width: got %h want ch0=1510 rest 1500", width_us); end
    checks++; if (o_done_at != hit || hit < 0) begin errors++; $display("FAIL small_done: got done at %0d want %0d", o_done_at, hit); end
  endtask

  task automatic test_clamp_err();
    bit to;
    wr(3, 0, 2500);
    wr(3, 1, 500);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clamp_err_low: got %b want 0", err); end
    wr(20, 0, 1800);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL addr_err: got %b want 1", err); end
    cyc();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b want 0", err); end
    wr(4, 6, 1800);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ch_err: got %b want 1", err); end
    gest(3);
    settle(to);
    checks++; if (to || width_us[15:0] !== 16'd2000 || width_us[31:16] !== 16'd1000) begin errors++; $display("FAIL clamp_width: got ch0=%0d ch1=%0d want 2000 1000", width_us[15:0], width_us[31:16]); end
    gest(4);
    settle(to);
    checks++; if (to || width_us !== {NC{16'd1500}}) begin errors++; $display("FAIL tbl_unchanged: got %h want %h", width_us, {NC{16'd1500}}); end
  endtask

  task automatic test_ignore();
    bit to;
    gest(0);
    checks++; if (err !== 1'b0 || busy !== 1'b0 || active_gesture !== 8'd4) begin errors++; $display("FAIL hold_code: got err=%b busy=%b act=%0d want 0 0 4", err, busy, active_gesture); end
    gest(16);
    checks++; if (err !== 1'b1 || busy !== 1'b0 || active_gesture !== 8'd4) begin errors++; $display("FAIL bad_code_idle: got err=%b busy=%b act=%0d want 1 0 4", err, busy, active_gesture); end
    gest(3);
    for (int k = 0; k < 30; k++) cyc();
    gest(16);
    checks++; if (err !== 1'b1 || busy !== 1'b1 || active_gesture !== 8'd3) begin errors++; $display("FAIL bad_code_ramp: got err=%b busy=%b act=%0d want 1 1 3", err, busy, active_gesture); end
    checks++; if (width_us !== exp_w()) begin errors++; $display("FAIL bad_code_width: got %h want %h", width_us, exp_w()); end
    settle(to);
  endtask

  task automatic test_retarget();
    int d0;
    bit to;
    do_reset();
    for (int c = 0; c < NC; c++) wr(1, c, 2000);
    for (int c = 0; c < NC; c++) wr(5, c, 1000);
    gest(1);
    for (int k = 0; k < 300 && m_cur[0] != 1700; k++) cyc();
    checks++; if (width_us[15:0] !== 16'd1700) begin errors++; $display("FAIL retarget_mid: got %0d want 1700", width_us[15:0]); end
    d0 = o_done_n;
    gest(5);
    to = 1;
    for (int k = 0; k < 600; k++) begin
      cyc();
      checks++; if (width_us !== exp_w()) begin errors++; $display("FAIL reverse_width: got %h want %h", width_us, exp_w()); end
      if (!(m_load || m_ramp)) begin to = 0; break; end
    end
    checks++; if (to || width_us !== {NC{16'd1000}}) begin errors++; $display("FAIL reverse_final: got %h want %h", width_us, {NC{16'd1000}}); end
    checks++; if (o_done_n - d0 != 1) begin errors++; $display("FAIL retarget_done: got %0d pulses want 1", o_done_n - d0); end
    gest(1);
    for (int k = 0; k < 50; k++) cyc();
    #2 reset = 0;
    #1;
    checks++; if (width_us !== {NC{16'd1500}} || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset: got w=%h busy=%b done=%b want 1500s 0 0", width_us, busy, done); end
    @(negedge clk);
    reset = 1;
    m_reset();
  endtask

  task automatic test_back_to_back();
    int d0;
    bit to;
    d0 = o_done_n;
    gest(1);
    cyc();
    gest(1);
    checks++; if (o_done_n != d0 || busy !== 1'b1) begin errors++; $display("FAIL accept_beats_done: got pulses=%0d busy=%b want 0 1", o_done_n - d0, busy); end
    settle(to);
    checks++; if (to || o_done_n - d0 != 1 || o_done_at != e_done_at || busy !== 1'b0) begin errors++; $display("FAIL b2b_done: got pulses=%0d at=%0d busy=%b want 1 at=%0d busy=0", o_done_n - d0, o_done_at, busy, e_done_at); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) begin gesture_valid = 1; gesture = GW'($urandom_range(0, 20)); end
      if ($urandom_range(0, 7) == 0) begin
        tbl_we = 1; tbl_addr = GW'($urandom_range(0, 19)); tbl_ch = 3'($urandom_range(0, 6)); tbl_data = WW'($urandom_range(700, 2400));
      end
      cyc();
      checks++; if (width_us !== exp_w()) begin errors++; $display("FAIL rnd_width: got %h want %h", width_us, exp_w()); end
      checks++; if (busy !== (m_load || m_ramp) || err !== m_err || active_gesture !== GW'(m_act)) begin errors++; $display("FAIL rnd_ctrl: got busy=%b err=%b act=%0d want %b %b %0d", busy, err, active_gesture, m_load || m_ramp, m_err, m_act); end
      checks++; if (o_done_n != e_done_n) begin errors++; $display("FAIL rnd_done: got %0d pulses want %0d", o_done_n, e_done_n); end
    end
  endtask

  initial begin
    test_reset();
    test_full_ramp();
    test_small_step();
    test_clamp_err();
    test_ignore();
    test_retarget();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
